// File: rtl/uart_tx_sequencer_if.sv
// uart_tx_sequencer_if: byte handshake plus serial and status lines of the UART transmitter.
interface uart_tx_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              tx;
  logic              busy;
  logic              bit_tick;
  modport master (output tx_valid, tx_data, input tx_ready, tx, busy, bit_tick);
  modport slave (input tx_valid, tx_data, output tx_ready, tx, busy, bit_tick);
endinterface

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: 8N1 UART transmitter that owns and sequences its bit-period divider.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_sequencer #(
  parameter int CLK_DIV = 10000,
  parameter int CNT_W   = 15,
  parameter int DATA_W  = 8
) (
  input logic                clk,
  input logic                reset,
  uart_tx_sequencer_if.slave bus
);
  localparam logic [CNT_W-1:0] PRE = CNT_W'(CLK_DIV - 2);
  localparam int IDX_W = ($clog2(DATA_W) > 0) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic par_q;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] sh_q;
  logic              tx_q, ready_q, busy_q, tick_q;
  if (CLK_DIV < 2 || CLK_DIV > (1 << CNT_W) - 1) begin : g_bad_div
    $error("uart_tx_sequencer: CLK_DIV %0d outside 2..2^CNT_W-1", CLK_DIV);
  end
  always_comb cnt_d = (state_q == IDLE || tick_q) ? '0 : cnt_q + 1'b1;
  // tick_q is registered one cycle early so it is high exactly while cnt_q == CLK_DIV-1
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= state_q != IDLE && cnt_q == PRE;
      case (state_q)
        IDLE: if (bus.tx_valid) begin
          state_q <= START;
          sh_q    <= bus.tx_data;
          idx_q   <= '0;
          tx_q    <= 1'b0;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
          par_q   <= ^bus.tx_data;
`endif
        end
        START: if (tick_q) begin
          state_q <= DATA;
          tx_q    <= sh_q[0];
        end
        DATA: if (tick_q) begin
          sh_q  <= sh_q >> 1;
          idx_q <= idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_q <= PARITY;
            tx_q    <= par_q;
`else
            state_q <= STOP;
            tx_q    <= 1'b1;
`endif
          end else begin
            tx_q <= sh_q[1];
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (tick_q) begin
          state_q <= STOP;
          tx_q    <= 1'b1;
        end
`endif
        STOP: if (tick_q) begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.tx       = tx_q;
  assign bus.tx_ready = ready_q;
  assign bus.busy     = busy_q;
  assign bus.bit_tick = tick_q;
endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb_uart_tx_sequencer: table-driven frame checks with a scoreboard of expected tx bit patterns.
module tb_uart_tx_sequencer;
`ifdef UART_TX_PARITY_EN
  localparam int DIV = 2;
  localparam int NB  = 11;
`else
  localparam int DIV = 4;
  localparam int NB  = 10;
`endif
  localparam int FRAME = NB * DIV;
  typedef struct {
    logic [7:0] d;
    logic [7:0] d_after;
    bit         hold;
    bit         chain;
    logic [9:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  time last_t = 0;
  bit prev_chain = 1'b0;
  logic [NB-1:0] sb_q[$];
  vec_t tbl[5];
  vec_t v_abort;
  uart_tx_sequencer_if #(.DATA_W(8)) u_if ();
  uart_tx_sequencer #(.CLK_DIV(DIV), .CNT_W(15), .DATA_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .bus(u_if)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [NB-1:0] frame_of(input vec_t v);
`ifdef UART_TX_PARITY_EN
    return {v.exp[9:1], ^v.d, 1'b1};
`else
    return v.exp;
`endif
  endfunction
  task automatic run_frame(input vec_t v);
    logic [NB-1:0] got, want, ref_f;
    int busy_n, tick_n, tick_bad, tx_bad, rdy_bad;
    busy_n = 0; tick_n = 0; tick_bad = 0; tx_bad = 0; rdy_bad = 0; got = '0;
    ref_f = frame_of(v);
    check("ready_before", 32'(u_if.tx_ready), 1);
    u_if.tx_valid = 1'b1;
    u_if.tx_data  = v.d;
    sb_q.push_back(ref_f);
    @(posedge clk);
    if (prev_chain) check("b2b_gap", 32'(($time - last_t) / 10), FRAME + 1);
    last_t = $time;
    @(negedge clk);
    u_if.tx_data = v.d_after;
    if (!v.hold) u_if.tx_valid = 1'b0;
    for (int c = 0; c < FRAME; c++) begin
      if (c > 0) @(negedge clk);
      if (u_if.busy === 1'b1) busy_n++;
      if (u_if.bit_tick === 1'b1) tick_n++;
      if (u_if.bit_tick !== (c % DIV == DIV - 1)) tick_bad++;
      if (u_if.tx !== ref_f[NB-1-c/DIV]) tx_bad++;
      if (u_if.tx_ready !== 1'b0) rdy_bad++;
      if (c % DIV == DIV / 2) got[NB-1-c/DIV] = u_if.tx;
    end
    @(negedge clk);
    want = sb_q.pop_front();
    check("frame_bits", 32'(got), 32'(want));
    check("tx_per_cycle_errs", tx_bad, 0);
    check("busy_cycles", busy_n, FRAME);
    check("tick_count", tick_n, NB);
    check("tick_place_errs", tick_bad, 0);
    check("ready_low_errs", rdy_bad, 0);
    check("ready_end", 32'(u_if.tx_ready), 1);
    check("busy_end", 32'(u_if.busy), 0);
    check("tx_end", 32'(u_if.tx), 1);
    prev_chain = v.chain;
    if (!v.chain) u_if.tx_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{8'hA5, 8'hA5, 1'b0, 1'b0, 10'b0101001011};
    tbl[1] = '{8'h3C, 8'hFF, 1'b1, 1'b0, 10'b0001111001};
    tbl[2] = '{8'h00, 8'h00, 1'b1, 1'b1, 10'b0000000001};
    tbl[3] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 10'b0111111111};
    tbl[4] = '{8'h01, 8'h01, 1'b0, 1'b0, 10'b0100000001};
    v_abort = '{8'h0F, 8'h0F, 1'b0, 1'b0, 10'b0111100001};
    u_if.tx_valid = 1'b0;
    u_if.tx_data  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    u_if.tx_valid = 1'b1;
    u_if.tx_data  = 8'hA5;
    @(negedge clk);
    check("rst_tx", 32'(u_if.tx), 1);
    check("rst_ready", 32'(u_if.tx_ready), 1);
    check("rst_busy", 32'(u_if.busy), 0);
    check("rst_tick", 32'(u_if.bit_tick), 0);
    reset = 1'b0;
    u_if.tx_valid = 1'b0;
    @(negedge clk);
    check("no_start_busy", 32'(u_if.busy), 0);
    check("no_start_tx", 32'(u_if.tx), 1);
    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i]);
      if (!tbl[i].chain) begin
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(u_if.busy), 0);
        check("idle_tx", 32'(u_if.tx), 1);
      end
    end
    u_if.tx_data  = 8'h55;
    u_if.tx_valid = 1'b1;
    @(negedge clk);
    u_if.tx_valid = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_pre_busy", 32'(u_if.busy), 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_tx", 32'(u_if.tx), 1);
    check("abort_ready", 32'(u_if.tx_ready), 1);
    check("abort_busy", 32'(u_if.busy), 0);
    check("abort_tick", 32'(u_if.bit_tick), 0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_idle_tx", 32'(u_if.tx), 1);
    prev_chain = 1'b0;
    run_frame(v_abort);
    check("sb_empty", 32'(sb_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
